// File: rtl/trivium_pkg.sv
// trivium_pkg: shared constants, FSM encoding and state-load helper for the
// Trivium cipher stage.
// Build option: TRIVIUM_UNROLL8_EN selects 8 rounds per clock instead of 1.
package trivium_pkg;

  localparam int unsigned STATE_W     = 288;
  localparam int unsigned INIT_ROUNDS = 1152;
  localparam int unsigned KEY_W       = 80;
  localparam int unsigned BYTE_W      = 8;

`ifdef TRIVIUM_UNROLL8_EN
  localparam int unsigned RPC = 8;
`else
  localparam int unsigned RPC = 1;
`endif

  localparam int unsigned INIT_CYCLES = INIT_ROUNDS / RPC;
  localparam int unsigned GEN_CYCLES  = BYTE_W / RPC;
  localparam int unsigned CNT_W       = 11;

  // Register boundaries (1-based length of A, end of B)
  localparam int unsigned A_LEN = 93;
  localparam int unsigned B_END = 177;

  // Tap positions, 1-based as in the Trivium description
  localparam int unsigned T1_A = 66;
  localparam int unsigned T1_B = 93;
  localparam int unsigned T1_P = 91;
  localparam int unsigned T1_Q = 92;
  localparam int unsigned T1_C = 171;
  localparam int unsigned T2_A = 162;
  localparam int unsigned T2_B = 177;
  localparam int unsigned T2_P = 175;
  localparam int unsigned T2_Q = 176;
  localparam int unsigned T2_C = 264;
  localparam int unsigned T3_A = 243;
  localparam int unsigned T3_B = 288;
  localparam int unsigned T3_P = 286;
  localparam int unsigned T3_Q = 287;
  localparam int unsigned T3_C = 69;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_INIT,
    ST_IDLE,
    ST_GEN,
    ST_WRITE
  } state_e;

  // Initial state: s1.. = key, s94.. = IV, s286..s288 = 1, rest 0
  function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                    input logic [KEY_W-1:0] iv);
    logic [STATE_W-1:0] s;
    s                              = '0;
    s[KEY_W-1:0]                   = key;
    s[A_LEN+KEY_W-1:A_LEN]         = iv;
    s[STATE_W-1:STATE_W-3]         = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_round.sv
// trivium_round: one combinational Trivium round.
// Ports: s_i  current state (bit k-1 holds s_k)
//        s_o  state after one round
//        z_o  keystream bit of this round
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] s_i,
  output logic [STATE_W-1:0] s_o,
  output logic               z_o
);

  logic t1, t2, t3;
  logic t1_fb, t2_fb, t3_fb;

  always_comb begin
    t1    = s_i[T1_A-1] ^ s_i[T1_B-1];
    t2    = s_i[T2_A-1] ^ s_i[T2_B-1];
    t3    = s_i[T3_A-1] ^ s_i[T3_B-1];
    z_o   = t1 ^ t2 ^ t3;
    t1_fb = t1 ^ (s_i[T1_P-1] & s_i[T1_Q-1]) ^ s_i[T1_C-1];
    t2_fb = t2 ^ (s_i[T2_P-1] & s_i[T2_Q-1]) ^ s_i[T2_C-1];
    t3_fb = t3 ^ (s_i[T3_P-1] & s_i[T3_Q-1]) ^ s_i[T3_C-1];
    // Each register shifts up by one; feedback enters at its first bit
    s_o   = {s_i[STATE_W-2:B_END], t2_fb,
             s_i[B_END-2:A_LEN],   t1_fb,
             s_i[A_LEN-2:0],       t3_fb};
  end

endmodule

// File: rtl/trivium_cipher.sv
// trivium_cipher: Trivium stream-cipher stage between the UART receiver and
// the transmit FIFO. Loads KEY/IV, runs the warm-up, then XORs each received
// byte with the next 8 keystream bits (first z in bit 0).
// Ports: clk, rst_n (async active-low), ena (global hold when low)
//        rx_data/rx_valid   received byte and its strobe
//        fifo_full          FIFO cannot take a write
//        enc_data           cipher byte, fifo_wr_en write strobe
//        encryption_done    pulse with fifo_wr_en
//        init_done          warm-up finished, overrun dropped-byte pulse
// Build option: TRIVIUM_UNROLL8_EN runs 8 rounds per clock.
module trivium_cipher
  import trivium_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY = 80'h0,
  parameter logic [KEY_W-1:0] IV  = 80'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              fifo_full,
  output logic [BYTE_W-1:0] enc_data,
  output logic              fifo_wr_en,
  output logic              encryption_done,
  output logic              init_done,
  output logic              overrun
);

  state_e              state_q, state_d;
  logic [STATE_W-1:0]  s_q, s_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   ks_q, ks_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [BYTE_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_valid_q, hold_valid_d;
  logic [BYTE_W-1:0]   enc_data_q, enc_data_d;
  logic                fifo_wr_en_q, fifo_wr_en_d;
  logic                done_q, done_d;
  logic                init_done_q, init_done_d;
  logic                overrun_q, overrun_d;

  logic                take;
  logic [BYTE_W-1:0]   ks_next;

  // Round datapath: RPC rounds chained per clock
  logic [STATE_W-1:0]  s_chain [RPC+1];
  logic [RPC-1:0]      z_vec;

  assign s_chain[0] = s_q;

  for (genvar gi = 0; gi < int'(RPC); gi++) begin : g_round
    trivium_round u_round (
      .s_i (s_chain[gi]),
      .s_o (s_chain[gi+1]),
      .z_o (z_vec[gi])
    );
  end

`ifdef TRIVIUM_UNROLL8_EN
  assign ks_next = z_vec;
`else
  // Shift in from the top so the first z ends up in bit 0 after 8 rounds
  assign ks_next = {z_vec[0], ks_q[BYTE_W-1:1]};
`endif

  // FSM takes a byte in IDLE, from the hold register or straight from rx
  assign take = (state_q == ST_IDLE) && (hold_valid_q || rx_valid);

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    cnt_d        = cnt_q;
    ks_d         = ks_q;
    byte_d       = byte_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q && !take;
    enc_data_d   = enc_data_q;
    fifo_wr_en_d = 1'b0;
    done_d       = 1'b0;
    init_done_d  = init_done_q;
    overrun_d    = 1'b0;

    // One-entry hold; a byte bypassing into the FSM does not occupy it
    if (rx_valid) begin
      if (hold_valid_q && !take) begin
        overrun_d = 1'b1;
      end else if (hold_valid_q || !take) begin
        hold_data_d  = rx_data;
        hold_valid_d = 1'b1;
      end
    end

    case (state_q)
      ST_LOAD: begin
        s_d     = load_state(KEY, IV);
        cnt_d   = '0;
        state_d = ST_INIT;
      end
      ST_INIT: begin
        s_d   = s_chain[RPC];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          cnt_d       = '0;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (take) begin
          byte_d  = hold_valid_q ? hold_data_q : rx_data;
          cnt_d   = '0;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        s_d   = s_chain[RPC];
        ks_d  = ks_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(GEN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Stall here with keystream frozen while the FIFO is full
        if (!fifo_full) begin
          enc_data_d   = byte_q ^ ks_q;
          fifo_wr_en_d = 1'b1;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State registers; ena low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      s_q          <= '0;
      cnt_q        <= '0;
      ks_q         <= '0;
      byte_q       <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      enc_data_q   <= '0;
      fifo_wr_en_q <= 1'b0;
      done_q       <= 1'b0;
      init_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      ks_q         <= ks_d;
      byte_q       <= byte_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      enc_data_q   <= enc_data_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      done_q       <= done_d;
      init_done_q  <= init_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign enc_data        = enc_data_q;
  assign fifo_wr_en      = fifo_wr_en_q;
  assign encryption_done = done_q;
  assign init_done       = init_done_q;
  assign overrun         = overrun_q;

endmodule
